// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word, RAM status and memory arbiter state types
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IGRANT = 3'd1,
    DGRANT = 3'd2,
    IDONE  = 3'd3,
    DDONE  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between fetch and data requesters
// Optional fetch starvation guard compiled in with MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        memerr
);

  arb_state_t state, next_state;
  ramstate_t  rs;
  word_t      req_addr, req_data;
  logic       req_wr;
  logic       dreq, grant_i, grant_d, load_i, load_d, err;
  logic       starve_hit, ram_active;

  assign rs   = ramstate_t'(ramstate);
  assign dreq = dREN | dWEN;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign starve_hit = iREN && (starve_cnt == 4'(STARVE_LIMIT));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_cnt <= '0;
    end else if (grant_i || (state == IDLE && !iREN)) begin
      starve_cnt <= '0;
    end else if (grant_d && iREN) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign starve_hit = 1'b0;
`endif

  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    load_i     = 1'b0;
    load_d     = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (starve_hit) begin
          grant_i    = 1'b1;
          next_state = IGRANT;
        end else if (dreq) begin
          grant_d    = 1'b1;
          next_state = DGRANT;
        end else if (iREN) begin
          grant_i    = 1'b1;
          next_state = IGRANT;
        end
      end
      // A dropped request wins over the RAM status: its strobe is already gone.
      IGRANT: begin
        if (!iREN) begin
          next_state = IDLE;
        end else if (rs == ACCESS) begin
          load_i     = 1'b1;
          next_state = IDONE;
        end else if (rs == ERROR) begin
          err        = 1'b1;
          next_state = IDLE;
        end
      end
      DGRANT: begin
        if (!dreq) begin
          next_state = IDLE;
        end else if (rs == ACCESS) begin
          load_d     = 1'b1;
          next_state = DDONE;
        end else if (rs == ERROR) begin
          err        = 1'b1;
          next_state = IDLE;
        end
      end
      IDONE:   next_state = IDLE;
      DDONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign ram_active = (state == IGRANT && iREN) || (state == DGRANT && dreq);
  assign ramREN     = ram_active && !req_wr;
  assign ramWEN     = ram_active && req_wr;
  assign ramaddr    = ram_active ? req_addr : '0;
  assign ramstore   = ram_active ? req_data : '0;
  assign ihit       = (state == IDONE);
  assign dhit       = (state == DDONE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      req_addr <= '0;
      req_data <= '0;
      req_wr   <= 1'b0;
      iload    <= '0;
      dload    <= '0;
      memerr   <= 1'b0;
    end else begin
      state  <= next_state;
      memerr <= err;
      if (grant_d) begin
        req_addr <= daddr;
        req_data <= dstore;
        req_wr   <= dWEN;
      end else if (grant_i) begin
        req_addr <= iaddr;
        req_data <= '0;
        req_wr   <= 1'b0;
      end
      if (load_i) iload <= ramload;
      if (load_d && !req_wr) dload <= ramload;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed-vector bench for mem_arbiter
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK, RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        ramREN, ramWEN, ihit, dhit, memerr;
  logic [31:0] ramaddr, ramstore, iload, dload;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.STARVE_LIMIT(2)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ramstate(ramstate), .ramload(ramload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload), .memerr(memerr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
  endtask

  logic [31:0] grants [6];
  logic [31:0] exp_grants [6];
  int          ng;

  initial begin
    RST = 1; iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    idle_inputs();
    #1;
    check_vec("rst_ramREN", {31'd0, ramREN}, 0);
    check_vec("rst_ramaddr", ramaddr, 0);
    check_vec("rst_iload", iload, 0);
    check_vec("rst_hits", {30'd0, ihit, dhit}, 0);
    @(negedge CLK); @(negedge CLK);
    RST = 0;
    @(negedge CLK);

    // single fetch, zero-wait RAM
    iREN = 1; iaddr = 32'h0000_0040;
    @(negedge CLK);
    check_vec("f_ramREN", {31'd0, ramREN}, 1);
    check_vec("f_ramaddr", ramaddr, 32'h40);
    check_vec("f_ihit_early", {31'd0, ihit}, 0);
    ramstate = ACCESS; ramload = 32'h2001_0005;
    @(negedge CLK);
    check_vec("f_ihit", {31'd0, ihit}, 1);
    check_vec("f_iload", iload, 32'h2001_0005);
    check_vec("f_ramREN_done", {31'd0, ramREN}, 0);
    idle_inputs();
    @(negedge CLK);
    check_vec("f_ihit_once", {31'd0, ihit}, 0);

    // error in DGRANT, retry by holding dREN
    dREN = 1; daddr = 32'h100;
    @(negedge CLK);
    check_vec("e_ramREN", {31'd0, ramREN}, 1);
    ramstate = ERROR;
    @(negedge CLK);
    check_vec("e_memerr", {31'd0, memerr}, 1);
    check_vec("e_dhit", {31'd0, dhit}, 0);
    check_vec("e_idle_strobe", {31'd0, ramREN}, 0);
    ramstate = FREE;
    @(negedge CLK);
    check_vec("e_memerr_once", {31'd0, memerr}, 0);
    check_vec("e_regrant", {31'd0, ramREN}, 1);
    check_vec("e_regrant_addr", ramaddr, 32'h100);
    ramstate = ACCESS; ramload = 32'hCAFE_F00D;
    @(negedge CLK);
    check_vec("e_dhit_retry", {31'd0, dhit}, 1);
    check_vec("e_dload", dload, 32'hCAFE_F00D);
    idle_inputs();
    @(negedge CLK);

    // collision: write wins, fetch follows
    iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
    @(negedge CLK);
    check_vec("c_ramWEN", {30'd0, ramWEN, ramREN}, 2);
    check_vec("c_ramaddr", ramaddr, 32'h80);
    check_vec("c_ramstore", ramstore, 32'hDEAD_BEEF);
    ramstate = ACCESS; ramload = 32'h0BAD_0BAD;
    @(negedge CLK);
    check_vec("c_dhit", {31'd0, dhit}, 1);
    check_vec("c_dload_kept", dload, 32'hCAFE_F00D);
    dWEN = 0; ramstate = FREE;
    @(negedge CLK);
    check_vec("c_idle", {30'd0, ramWEN, ramREN}, 0);
    @(negedge CLK);
    check_vec("c_fetch_strobe", {30'd0, ramWEN, ramREN}, 1);
    check_vec("c_fetch_addr", ramaddr, 32'h44);
    check_vec("c_fetch_store", ramstore, 0);
    ramstate = ACCESS; ramload = 32'h1111_2222;
    @(negedge CLK);
    check_vec("c_ihit", {31'd0, ihit}, 1);
    check_vec("c_iload", iload, 32'h1111_2222);
    idle_inputs();
    @(negedge CLK);

    // abort while BUSY
    dREN = 1; daddr = 32'h200; ramstate = BUSY;
    @(negedge CLK);
    check_vec("a_ramREN", {31'd0, ramREN}, 1);
    dREN = 0;
    #1;
    check_vec("a_drop_same_cycle", {31'd0, ramREN}, 0);
    check_vec("a_drop_addr", ramaddr, 0);
    @(negedge CLK);
    check_vec("a_no_dhit", {31'd0, dhit}, 0);
    check_vec("a_no_err", {31'd0, memerr}, 0);
    check_vec("a_dload_kept", dload, 32'hCAFE_F00D);
    idle_inputs();
    @(negedge CLK);

    // continuous competing requests: grant order
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_grants = '{32'h300, 32'h300, 32'h400, 32'h300, 32'h300, 32'h400};
`else
    exp_grants = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h300, 32'h300};
`endif
    grants = '{default: 32'h0};
    ng = 0;
    dREN = 1; iREN = 1; daddr = 32'h300; iaddr = 32'h400;
    ramstate = ACCESS; ramload = 32'h5A5A_5A5A;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      @(negedge CLK);
      if (ramREN) begin
        grants[ng] = ramaddr;
        ng++;
      end
    end
    for (int k = 0; k < 6; k++) check_vec($sformatf("s_grant%0d", k), grants[k], exp_grants[k]);
    idle_inputs();
    repeat (3) @(negedge CLK);

    // reset mid-access
    dREN = 1; daddr = 32'h500; ramstate = BUSY;
    @(negedge CLK);
    check_vec("r_pre_ramREN", {31'd0, ramREN}, 1);
    check_vec("r_pre_dload", dload, 32'h5A5A_5A5A);
    #1 RST = 1;
    #1;
    check_vec("r_ramREN", {31'd0, ramREN}, 0);
    check_vec("r_ramaddr", ramaddr, 0);
    check_vec("r_dload", dload, 0);
    check_vec("r_iload", iload, 0);
    @(negedge CLK);
    RST = 0;
    idle_inputs();
    @(negedge CLK);
    check_vec("r_no_dhit", {31'd0, dhit}, 0);
    check_vec("r_idle_strobe", {30'd0, ramWEN, ramREN}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
